// File: rtl/case_convert_stream.sv
// ----------------------------------------------------------------------------
// case_convert_stream
//   Streaming ASCII case converter. LANES bytes per beat, one output register
//   stage, mode latched per packet, plus conversion and packet statistics.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mode              00 pass, 01 upper, 10 lower, 11 toggle case
//   stat_clr          synchronous clear of conv_count and pkt_count
//   s_valid/s_ready   input handshake
//   s_data/s_keep     input bytes (lane 0 = bits [7:0]) and per-lane valid
//   s_last            final beat of packet
//   m_valid/m_ready   output handshake
//   m_data/m_keep     converted bytes (keep=0 lanes are 0x00), keep copy
//   m_last            last copy
//   conv_count        bytes changed by conversion (saturating)
//   pkt_count         packets accepted (wrapping)
//   fsm_state         debug view of the packet FSM (0 = IDLE, 1 = IN_PKT)
// ----------------------------------------------------------------------------
module case_convert_stream #(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           mode,
   input  logic                 stat_clr,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [8*LANES-1:0]   s_data,
   input  logic [LANES-1:0]     s_keep,
   input  logic                 s_last,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [8*LANES-1:0]   m_data,
   output logic [LANES-1:0]     m_keep,
   output logic                 m_last,
   output logic [CNT_W-1:0]     conv_count,
   output logic [CNT_W-1:0]     pkt_count,
   output logic                 fsm_state
);

   localparam int PW = $clog2(LANES + 1);

   typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

   state_t             state;
   logic [1:0]         mode_q;
   logic [1:0]         eff_mode;
   logic               accept;
   logic [8*LANES-1:0] conv_data;
   logic [LANES-1:0]   changed;
   logic [PW-1:0]      n_changed;
   logic [CNT_W:0]     conv_sum;
   logic [CNT_W-1:0]   conv_next;
   logic [7:0]         b;
   logic [7:0]         nb;
   logic               is_lo;
   logic               is_up;

   // Handshake: a beat transfers on any rising edge where valid & ready are
   // both high. The source may not withdraw a beat once valid is raised; the
   // output register refills whenever it is empty or being drained this cycle.
   assign s_ready   = !m_valid || m_ready;
   assign accept    = s_valid && s_ready;
   assign fsm_state = (state == IN_PKT);

   // The first beat of a packet uses the live mode; later beats use the latch.
   assign eff_mode = (state == IDLE) ? mode : mode_q;

   always_comb begin
      conv_data = '0;
      changed   = '0;
      b         = '0;
      nb        = '0;
      is_lo     = 1'b0;
      is_up     = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         b     = s_data[8*i +: 8];
         is_lo = (b >= 8'h61) && (b <= 8'h7A);
         is_up = (b >= 8'h41) && (b <= 8'h5A);
         nb    = b;
         case (eff_mode)
            2'b01:   if (is_lo) nb = b & 8'hDF;
            2'b10:   if (is_up) nb = b | 8'h20;
            2'b11:   if (is_lo || is_up) nb = b ^ 8'h20;
            default: nb = b;
         endcase
         // Dropped lanes read as zero and never count as changed.
         if (s_keep[i]) begin
            conv_data[8*i +: 8] = nb;
            changed[i]          = (nb != b);
         end
      end
   end

   always_comb begin
      n_changed = '0;
      for (int i = 0; i < LANES; i++)
         n_changed = n_changed + PW'(changed[i]);
   end

   // One spare bit catches overflow so the counter can clamp at all-ones.
   assign conv_sum  = {1'b0, conv_count} + (CNT_W + 1)'(n_changed);
   assign conv_next = conv_sum[CNT_W] ? '1 : conv_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mode_q     <= 2'b00;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_keep     <= '0;
         m_last     <= 1'b0;
         conv_count <= '0;
         pkt_count  <= '0;
      end else begin
         // Output register: refill on accept, empty on drain with no refill,
         // hold otherwise.
         if (s_ready) begin
            m_valid <= s_valid;
            if (s_valid) begin
               m_data <= conv_data;
               m_keep <= s_keep;
               m_last <= s_last;
            end
         end

         if (accept) begin
            case (state)
               IDLE: begin
                  mode_q <= mode;
                  if (!s_last) state <= IN_PKT;
               end
               IN_PKT: begin
                  if (s_last) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end

         // Clear takes priority and discards the same-cycle increment.
         if (stat_clr) begin
            conv_count <= '0;
            pkt_count  <= '0;
         end else if (accept) begin
            conv_count <= conv_next;
            if (s_last) pkt_count <= pkt_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_case_convert_stream.sv
// ----------------------------------------------------------------------------
// tb_case_convert_stream
//   Directed bench for case_convert_stream (LANES=4, CNT_W=4). A reference
//   model classifies characters and queues expected output beats; a negedge
//   compare process checks every cycle; literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_case_convert_stream;

   localparam int LANES = 4;
   localparam int CNT_W = 4;
   localparam int DW    = 8 * LANES;
   localparam int BW    = DW + LANES + 1;
   localparam int CMAX  = (1 << CNT_W) - 1;

   // ---------------- clock / reset / signals ----------------
   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       mode;
   logic             stat_clr;
   logic             s_valid;
   logic             s_ready;
   logic [DW-1:0]    s_data;
   logic [LANES-1:0] s_keep;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [DW-1:0]    m_data;
   logic [LANES-1:0] m_keep;
   logic             m_last;
   logic [CNT_W-1:0] conv_count;
   logic [CNT_W-1:0] pkt_count;
   logic             fsm_state;

   always #5 clk = ~clk;

   case_convert_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .stat_clr   (stat_clr),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_keep     (s_keep),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .m_last     (m_last),
      .conv_count (conv_count),
      .pkt_count  (pkt_count),
      .fsm_state  (fsm_state)
   );

   int total   = 0;
   int bad     = 0;
   bit started = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [BW-1:0] exp_q[$];
   bit            mdl_in_pkt;
   logic [1:0]    mdl_mode;
   int            mdl_conv;
   int            mdl_pkt;

   function automatic logic [7:0] ref_byte(input logic [7:0] c, input logic [1:0] md);
      bit lo = (int'(c) >= 97) && (int'(c) <= 122);  // 'a'..'z'
      bit up = (int'(c) >= 65) && (int'(c) <= 90);   // 'A'..'Z'
      case (md)
         2'd1:    return lo ? c - 8'd32 : c;
         2'd2:    return up ? c + 8'd32 : c;
         2'd3:    return lo ? c - 8'd32 : (up ? c + 8'd32 : c);
         default: return c;
      endcase
   endfunction

   always @(posedge clk) begin : model
      bit            rdy;
      logic [1:0]    md;
      logic [DW-1:0] d;
      logic [7:0]    ob;
      int            n;
      bit            acc;
      if (rst) begin
         exp_q.delete();
         mdl_in_pkt = 1'b0;
         mdl_conv   = 0;
         mdl_pkt    = 0;
      end else begin
         rdy = (exp_q.size() == 0) || m_ready;
         acc = s_valid && rdy;
         n   = 0;
         if (exp_q.size() != 0 && m_ready) void'(exp_q.pop_front());
         if (acc) begin
            md = mdl_in_pkt ? mdl_mode : mode;
            if (!mdl_in_pkt) mdl_mode = mode;
            d = '0;
            for (int i = 0; i < LANES; i++) begin
               if (s_keep[i]) begin
                  ob = ref_byte(s_data[8*i +: 8], md);
                  d[8*i +: 8] = ob;
                  if (ob != s_data[8*i +: 8]) n++;
               end
            end
            exp_q.push_back({s_last, s_keep, d});
            mdl_in_pkt = !s_last;
         end
         if (stat_clr) begin
            mdl_conv = 0;
            mdl_pkt  = 0;
         end else if (acc) begin
            mdl_conv = (mdl_conv + n > CMAX) ? CMAX : mdl_conv + n;
            if (s_last) mdl_pkt = (mdl_pkt + 1) % (CMAX + 1);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin : compare
      logic [BW-1:0] e;
      if (started) begin
         check("cmp_s_ready", 32'(s_ready), 32'((exp_q.size() == 0) || m_ready));
         check("cmp_m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("cmp_m_data", m_data, e[DW-1:0]);
            check("cmp_m_keep", 32'(m_keep), 32'(e[DW +: LANES]));
            check("cmp_m_last", 32'(m_last), 32'(e[BW-1]));
         end
         check("cmp_conv_count", 32'(conv_count), 32'(mdl_conv));
         check("cmp_pkt_count", 32'(pkt_count), 32'(mdl_pkt));
         check("cmp_fsm_state", 32'(fsm_state), 32'(mdl_in_pkt));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [LANES-1:0] k,
                       input logic l, input logic [1:0] md, input logic clr);
      int n;
      bit acc;
      n   = 0;
      acc = 1'b0;
      s_valid  = 1'b1;
      s_data   = d;
      s_keep   = k;
      s_last   = l;
      mode     = md;
      stat_clr = clr;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         n++;
      end
      check("send_accepted", 32'(acc), 32'd1);
      s_valid  = 1'b0;
      stat_clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; mode = 2'b00; stat_clr = 1'b0; s_valid = 1'b0;
      s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      started = 1'b1;

      // reset state
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_m_data", m_data, 0);
      check("rst_conv", 32'(conv_count), 0);
      check("rst_pkt", 32'(pkt_count), 0);
      check("rst_s_ready", 32'(s_ready), 1);
      check("rst_fsm", 32'(fsm_state), 0);

      // upper-case a mixed beat
      send(32'h7A486128, 4'hF, 1'b1, 2'b01, 1'b0);
      check("t1_data", m_data, 32'h5A484128);
      check("t1_conv", 32'(conv_count), 2);
      check("t1_pkt", 32'(pkt_count), 1);

      // high-bit and DEL bytes pass in every mode
      for (int md = 0; md < 4; md++) begin
         send(32'h7FEB83B7, 4'hF, 1'b1, md[1:0], 1'b0);
         check("t2_data", m_data, 32'h7FEB83B7);
      end
      check("t2_conv", 32'(conv_count), 2);
      check("t2_pkt", 32'(pkt_count), 5);

      // mode held across a packet, relatched for the next one
      send(32'h44434241, 4'hF, 1'b0, 2'b10, 1'b0);
      check("t3_b0", m_data, 32'h64636261);
      check("t3_fsm_in", 32'(fsm_state), 1);
      send(32'h61424344, 4'hF, 1'b0, 2'b01, 1'b0);
      check("t3_b1", m_data, 32'h61626364);
      send(32'h7A795857, 4'hF, 1'b1, 2'b01, 1'b0);
      check("t3_b2", m_data, 32'h7A797877);
      check("t3_fsm_idle", 32'(fsm_state), 0);
      send(32'h64636261, 4'hF, 1'b1, 2'b01, 1'b0);
      check("t3_next", m_data, 32'h44434241);
      check("t3_conv", 32'(conv_count), 15);

      // backpressure
      tick(1);
      m_ready = 1'b0;
      send(32'h2161615A, 4'hF, 1'b1, 2'b11, 1'b0);
      check("t4_first", m_data, 32'h2141417A);
      fork
         send(32'h64434261, 4'hF, 1'b1, 2'b11, 1'b0);
         begin
            repeat (3) begin
               @(negedge clk);
               check("t4_s_ready_low", 32'(s_ready), 0);
               check("t4_hold", m_data, 32'h2141417A);
            end
            @(posedge clk);
            #2 m_ready = 1'b1;
         end
      join
      check("t4_second", m_data, 32'h44636241);
      tick(1);
      check("t4_drained", 32'(m_valid), 0);

      // stand-alone clear, then partial keep in toggle mode
      stat_clr = 1'b1;
      tick(1);
      stat_clr = 1'b0;
      check("t5_clr_conv", 32'(conv_count), 0);
      check("t5_clr_pkt", 32'(pkt_count), 0);
      send(32'h61614141, 4'b0101, 1'b1, 2'b11, 1'b0);
      check("t5_data", m_data, 32'h00410061);
      check("t5_keep", 32'(m_keep), 32'h5);
      check("t5_conv", 32'(conv_count), 2);

      // saturation, wrap, clear-wins
      for (int i = 0; i < 5; i++) send(32'h64636261, 4'hF, 1'b1, 2'b11, 1'b0);
      check("t6_sat", 32'(conv_count), 15);
      check("t6_pkt", 32'(pkt_count), 6);
      for (int i = 0; i < 10; i++) send(32'h41414141, 4'h0, 1'b1, 2'b11, 1'b0);
      check("t6_zero_keep", m_data, 0);
      check("t6_wrap", 32'(pkt_count), 0);
      check("t6_sat_hold", 32'(conv_count), 15);
      send(32'h64636261, 4'hF, 1'b1, 2'b11, 1'b1);
      check("t6_clr_conv", 32'(conv_count), 0);
      check("t6_clr_pkt", 32'(pkt_count), 0);
      check("t6_clr_data", m_data, 32'h44434241);

      // reset mid-packet with a beat stuck in the output register
      send(32'h41424344, 4'hF, 1'b0, 2'b10, 1'b0);
      check("t7_conv_pre", 32'(conv_count), 4);
      m_ready = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      check("t7_m_valid", 32'(m_valid), 0);
      check("t7_m_data", m_data, 0);
      check("t7_m_keep", 32'(m_keep), 0);
      check("t7_m_last", 32'(m_last), 0);
      check("t7_conv", 32'(conv_count), 0);
      check("t7_pkt", 32'(pkt_count), 0);
      check("t7_fsm", 32'(fsm_state), 0);
      rst = 1'b0;
      m_ready = 1'b1;
      send(32'h64636261, 4'hF, 1'b1, 2'b01, 1'b0);
      check("t7_relatch", m_data, 32'h44434241);
      tick(2);
      check("end_idle", 32'(m_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
